hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It sits directly downstream of the hazard instruction decoder. Each cycle it takes the decoded Rs/Rt, Tuse and Tnew, and the destination register of the instruction in D, and tracks every in-flight producer in a small E/M/W scoreboard. From that it generates the D-stage stall / E-stage bubble and the forwarding mux selects for the D, E and M consumers.

## Interface
Parameters:
- none; all encodings come from the shared constants header.

Ports:
- HC_i_Clk  in  1  single clock, rising edge.
- HC_i_RstN  in  1  reset, asynchronous, active-low.
- HC_i_RsD  in  5  Rs of the instruction in D.
- HC_i_RtD  in  5  Rt of the instruction in D.
- HC_i_TuseRsD  in  4  Tuse of Rs: 0=D, 1=E, 2=M, 4'hF=never read.
- HC_i_TuseRtD  in  4  Tuse of Rt, same encoding as Rs.
- HC_i_TnewD  in  4  Tnew at D: 1=ID/EX, 2=EX/MEM, 3=MEM/WB, 4'hF=no write.
- HC_i_RegWAddrD  in  5  destination register of the instruction in D.
- HC_o_Stall  out  1  freeze PC and IF/ID, clear ID/EX.
- HC_o_FwdRsD  out  2  select for the D-stage Rs consumer (branch compare, jr).
- HC_o_FwdRtD  out  2  select for the D-stage Rt consumer.
- HC_o_FwdRsE  out  2  select for the E-stage Rs operand.
- HC_o_FwdRtE  out  2  select for the E-stage Rt operand.
- HC_o_FwdRtM  out  2  select for the M-stage Rt (store data).
- Forward select encoding: 0=register file / pipeline value, 1=ID/EX, 2=EX/MEM, 3=MEM/WB.

## Operation
Scoreboard:
- One entry per stage E, M, W.
- Producer fields per entry: valid, addr[4:0], tnew[3:0].
- Consumer fields: E holds rs, rt, tuseRs, tuseRt. M holds rt and tuseRt.

Producer validity:
- Valid = (TnewD != 4'hF) && (RegWAddrD != 0).

Register 0:
- Never matches anything.
- Never stalls and never forwards.

Stage advance on each rising edge:
- E <= D fields, with tnew = sat0(TnewD−1). When HC_o_Stall=1, E instead gets a bubble (all valid=0, tuse=4'hF).
- M <= E with tnew = sat0(tnewE−1).
- W <= M with tnew = sat0(tnewM−1).
- sat0 clamps at 0. The 4'hF no-write code is never decremented into a valid value; validity comes from the valid bit only.

Stall (combinational):
- Applies for each of Rs and Rt of D whose Tuse != 4'hF and whose register != 0.
- Find the youngest valid match, searching E then M.
- Stall if that match has tnew > Tuse.
- Older matches are ignored once a younger one is found.
- HC_o_Stall is the OR of the Rs and Rt results.

Forward selects (combinational, youngest match with tnew == 0 wins):
- D consumers: search E(1), then M(2), then W(3).
- E consumers: search M(2), then W(3).
- M consumer: search W(3).
- If there is no match, or the youngest match still has tnew > 0, the select is 0.
- Bubbles and never-read fields drive select 0.

## Timing
- Stall and all forward selects are combinational from the D inputs and scoreboard state in the same cycle; there are no added cycles of latency.
- Scoreboard state changes only on the rising edge of HC_i_Clk or on the asynchronous assertion of HC_i_RstN.
- During reset and after release:
  - all entries are invalid with tuse=4'hF;
  - Stall=0 and every Fwd*=0.
- Reset mid-stall: Stall drops in the same delta as HC_i_RstN falls; nothing is retained.
- Repeated stalls: each stalled cycle inserts one more bubble into E, while M and W keep draining, so the hazard resolves in at most 2 cycles (lw → D-use).
- Simultaneous matches in E and M: E wins for both stall and forward.

## Structure
Constants go in the shared header alongside the existing instruction macros:
- T_USE_AT_D/E/M.
- T_USE_NEVER_READ = 4'hF.
- T_NEW_AT_ID_EX / EX_MEM / MEM_WB.
- T_NEW_NO_NEW = 4'hF.
- FWD_RF / FWD_IDEX / FWD_EXMEM / FWD_MEMWB.

Sub-module:
- hazard_sb_stage: one scoreboard entry with async active-low reset, a bubble input, and saturating tnew decrement.
- It is instantiated three times.

## Test plan
- lw $1 then addu $2,$1,$1 → Stall=1 for 1 cycle. Next cycle FwdRsE=FwdRtE=3.
- lw $1 then beq $1,$0 → Stall=1 for 2 cycles, then FwdRsD=3. FwdRtD=0, since $0 never forwards.
- addu $3 then beq $3,$3 → Stall=1 for 1 cycle, then FwdRsD=FwdRtD=2.
- jal then jr $31 → Stall=0 and FwdRsD=1. One cycle later, an E consumer of $31 gets FwdRsE=2.
- lw $4 then sw $4,0($5) → Stall=0. When the sw reaches M, FwdRtM=3.
- Pull HC_i_RstN low while Stall=1 → Stall=0 immediately. After release, addu $6 with an immediately following reader of $6 behaves as a fresh pipeline.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard constants, scoreboard entry type and lookup helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    localparam logic [3:0] T_USE_AT_D       = 4'd0;
    localparam logic [3:0] T_USE_AT_E       = 4'd1;
    localparam logic [3:0] T_USE_AT_M       = 4'd2;
    localparam logic [3:0] T_USE_NEVER_READ = 4'hF;

    localparam logic [3:0] T_NEW_AT_ID_EX   = 4'd1;
    localparam logic [3:0] T_NEW_AT_EX_MEM  = 4'd2;
    localparam logic [3:0] T_NEW_AT_MEM_WB  = 4'd3;
    localparam logic [3:0] T_NEW_NO_NEW     = 4'hF;

    localparam logic [1:0] FWD_RF           = 2'd0;
    localparam logic [1:0] FWD_IDEX         = 2'd1;
    localparam logic [1:0] FWD_EXMEM        = 2'd2;
    localparam logic [1:0] FWD_MEMWB        = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [3:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [3:0] tuse_rs;
        logic [3:0] tuse_rt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{
        valid:   1'b0,
        addr:    5'd0,
        tnew:    4'd0,
        rs:      5'd0,
        rt:      5'd0,
        tuse_rs: T_USE_NEVER_READ,
        tuse_rt: T_USE_NEVER_READ
    };

    function automatic logic [3:0] sat_dec(input logic [3:0] t);
        return (t == 4'd0) ? 4'd0 : t - 4'd1;
    endfunction

    // $0 is hard-wired, so it can never be the target of a hazard.
    function automatic logic sb_hit(input sb_entry_t ent, input logic [4:0] r);
        return ent.valid && (r != 5'd0) && (ent.addr == r);
    endfunction

    function automatic logic op_stall(input sb_entry_t e, input sb_entry_t m,
                                      input logic [4:0] r, input logic [3:0] tuse);
        logic res;
        res = 1'b0;
        if (tuse != T_USE_NEVER_READ) begin
            if (sb_hit(e, r))
                res = (e.tnew > tuse);
            else if (sb_hit(m, r))
                res = (m.tnew > tuse);
        end
        return res;
    endfunction

    // srch enables E/M/W lookup (bit 0/1/2); the youngest enabled hit decides.
    function automatic logic [1:0] fwd_pick(input sb_entry_t e, input sb_entry_t m,
                                            input sb_entry_t w, input logic [2:0] srch,
                                            input logic [4:0] r, input logic [3:0] tuse);
        logic [1:0] sel;
        sel = FWD_RF;
        if (tuse != T_USE_NEVER_READ) begin
            if (srch[0] && sb_hit(e, r))
                sel = (e.tnew == 4'd0) ? FWD_IDEX : FWD_RF;
            else if (srch[1] && sb_hit(m, r))
                sel = (m.tnew == 4'd0) ? FWD_EXMEM : FWD_RF;
            else if (srch[2] && sb_hit(w, r))
                sel = (w.tnew == 4'd0) ? FWD_MEMWB : FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_sb_stage.sv
// One pipeline scoreboard entry with saturating tnew countdown.
// Latency: one cycle from d to q.
// Backpressure: bubble loads an empty entry instead of d.
module hazard_sb_stage
    import hazard_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      bubble,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SB_EMPTY;
        end else if (bubble) begin
            q <= SB_EMPTY;
        end else begin
            q      <= d;
            q.tnew <= sat_dec(d.tnew);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// E/M/W producer scoreboard driving D-stage stall and D/E/M forward selects.
// Latency: stall and selects are combinational from D inputs and scoreboard.
// Backpressure: Stall freezes D and injects a bubble into E.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       HC_i_Clk,
    input  logic       HC_i_RstN,
    input  logic [4:0] HC_i_RsD,
    input  logic [4:0] HC_i_RtD,
    input  logic [3:0] HC_i_TuseRsD,
    input  logic [3:0] HC_i_TuseRtD,
    input  logic [3:0] HC_i_TnewD,
    input  logic [4:0] HC_i_RegWAddrD,
    output logic       HC_o_Stall,
    output logic [1:0] HC_o_FwdRsD,
    output logic [1:0] HC_o_FwdRtD,
    output logic [1:0] HC_o_FwdRsE,
    output logic [1:0] HC_o_FwdRtE,
    output logic [1:0] HC_o_FwdRtM
);

    sb_entry_t d_ent, m_in, w_in;
    sb_entry_t e_q, m_q, w_q;

    always_comb begin
        d_ent         = SB_EMPTY;
        d_ent.valid   = (HC_i_TnewD != T_NEW_NO_NEW) && (HC_i_RegWAddrD != 5'd0);
        d_ent.addr    = HC_i_RegWAddrD;
        d_ent.tnew    = HC_i_TnewD;
        d_ent.rs      = HC_i_RsD;
        d_ent.rt      = HC_i_RtD;
        d_ent.tuse_rs = HC_i_TuseRsD;
        d_ent.tuse_rt = HC_i_TuseRtD;
    end

    // M only consumes store data (rt); W only produces.
    always_comb begin
        m_in         = e_q;
        m_in.rs      = 5'd0;
        m_in.tuse_rs = T_USE_NEVER_READ;
        w_in         = m_q;
        w_in.rs      = 5'd0;
        w_in.rt      = 5'd0;
        w_in.tuse_rs = T_USE_NEVER_READ;
        w_in.tuse_rt = T_USE_NEVER_READ;
    end

    hazard_sb_stage u_sb_e (
        .clk    (HC_i_Clk),
        .rst_n  (HC_i_RstN),
        .bubble (HC_o_Stall),
        .d      (d_ent),
        .q      (e_q)
    );

    hazard_sb_stage u_sb_m (
        .clk    (HC_i_Clk),
        .rst_n  (HC_i_RstN),
        .bubble (1'b0),
        .d      (m_in),
        .q      (m_q)
    );

    hazard_sb_stage u_sb_w (
        .clk    (HC_i_Clk),
        .rst_n  (HC_i_RstN),
        .bubble (1'b0),
        .d      (w_in),
        .q      (w_q)
    );

    always_comb begin
        HC_o_Stall  = op_stall(e_q, m_q, HC_i_RsD, HC_i_TuseRsD)
                    | op_stall(e_q, m_q, HC_i_RtD, HC_i_TuseRtD);
        HC_o_FwdRsD = fwd_pick(e_q, m_q, w_q, 3'b111, HC_i_RsD, HC_i_TuseRsD);
        HC_o_FwdRtD = fwd_pick(e_q, m_q, w_q, 3'b111, HC_i_RtD, HC_i_TuseRtD);
        HC_o_FwdRsE = fwd_pick(e_q, m_q, w_q, 3'b110, e_q.rs, e_q.tuse_rs);
        HC_o_FwdRtE = fwd_pick(e_q, m_q, w_q, 3'b110, e_q.rt, e_q.tuse_rt);
        HC_o_FwdRtM = fwd_pick(e_q, m_q, w_q, 3'b100, m_q.rt, m_q.tuse_rt);
    end

    logic unused_consumer;
    assign unused_consumer = ^{m_q.rs, m_q.tuse_rs, w_q.rs, w_q.rt, w_q.tuse_rs, w_q.tuse_rt};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: classic MIPS producer/consumer pairs.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, waddr_d;
    logic [3:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .HC_i_Clk       (clk),
        .HC_i_RstN      (rst_n),
        .HC_i_RsD       (rs_d),
        .HC_i_RtD       (rt_d),
        .HC_i_TuseRsD   (tuse_rs_d),
        .HC_i_TuseRtD   (tuse_rt_d),
        .HC_i_TnewD     (tnew_d),
        .HC_i_RegWAddrD (waddr_d),
        .HC_o_Stall     (stall),
        .HC_o_FwdRsD    (fwd_rs_d),
        .HC_o_FwdRtD    (fwd_rt_d),
        .HC_o_FwdRsE    (fwd_rs_e),
        .HC_o_FwdRtE    (fwd_rt_e),
        .HC_o_FwdRtM    (fwd_rt_m)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [3:0] urs, input logic [3:0] urt,
                         input logic [3:0] tn, input logic [4:0] wa);
        rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt;
        tnew_d = tn; waddr_d = wa;
        #2;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 4'hF, 4'hF, 4'hF, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        // Reader of $1 while in reset: scoreboard empty, nothing may fire.
        set_d(5'd1, 5'd1, 4'd0, 4'd0, 4'hF, 5'd0);
        chk("rst_stall", {3'b0, stall}, 4'd0);
        chk("rst_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd0);
        chk("rst_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd0);
        chk("rst_fwd_rt_m", {2'b0, fwd_rt_m}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drain();

        // lw $1,0($2) ; addu $2,$1,$1
        set_d(5'd2, 5'd1, 4'd1, 4'hF, 4'd3, 5'd1);
        chk("lw_alone_stall", {3'b0, stall}, 4'd0);
        tick();
        set_d(5'd1, 5'd1, 4'd1, 4'd1, 4'd2, 5'd2);
        chk("lw_addu_stall1", {3'b0, stall}, 4'd1);
        tick();
        chk("lw_addu_stall2", {3'b0, stall}, 4'd0);
        tick();
        nop();
        chk("lw_addu_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd3);
        chk("lw_addu_fwd_rt_e", {2'b0, fwd_rt_e}, 4'd3);
        drain();

        // lw $1,0($0) ; beq $1,$0
        set_d(5'd0, 5'd1, 4'd1, 4'hF, 4'd3, 5'd1);
        tick();
        set_d(5'd1, 5'd0, 4'd0, 4'd0, 4'hF, 5'd0);
        chk("lw_beq_stall1", {3'b0, stall}, 4'd1);
        chk("lw_beq_fwd_rs_d_c1", {2'b0, fwd_rs_d}, 4'd0);
        tick();
        chk("lw_beq_stall2", {3'b0, stall}, 4'd1);
        tick();
        chk("lw_beq_stall3", {3'b0, stall}, 4'd0);
        chk("lw_beq_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd3);
        chk("lw_beq_fwd_rt_d", {2'b0, fwd_rt_d}, 4'd0);
        drain();

        // addu $3,$0,$0 ; beq $3,$3
        set_d(5'd0, 5'd0, 4'd1, 4'd1, 4'd2, 5'd3);
        tick();
        set_d(5'd3, 5'd3, 4'd0, 4'd0, 4'hF, 5'd0);
        chk("addu_beq_stall1", {3'b0, stall}, 4'd1);
        tick();
        chk("addu_beq_stall2", {3'b0, stall}, 4'd0);
        chk("addu_beq_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd2);
        chk("addu_beq_fwd_rt_d", {2'b0, fwd_rt_d}, 4'd2);
        drain();

        // jal ; jr $31
        set_d(5'd0, 5'd0, 4'hF, 4'hF, 4'd1, 5'd31);
        tick();
        set_d(5'd31, 5'd0, 4'd0, 4'hF, 4'hF, 5'd0);
        chk("jal_jr_stall", {3'b0, stall}, 4'd0);
        chk("jal_jr_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd1);
        tick();
        nop();
        chk("jal_jr_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd2);
        drain();

        // lw $4,0($6) ; sw $4,0($5)
        set_d(5'd6, 5'd4, 4'd1, 4'hF, 4'd3, 5'd4);
        tick();
        set_d(5'd5, 5'd4, 4'd1, 4'd2, 4'hF, 5'd0);
        chk("lw_sw_stall", {3'b0, stall}, 4'd0);
        tick();
        nop();
        chk("lw_sw_fwd_rt_e", {2'b0, fwd_rt_e}, 4'd0);
        chk("lw_sw_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd0);
        tick();
        chk("lw_sw_fwd_rt_m", {2'b0, fwd_rt_m}, 4'd3);
        drain();

        // addu $7 ; addu $7 ; beq $7,$0 -- younger E producer must win
        set_d(5'd0, 5'd0, 4'd1, 4'd1, 4'd2, 5'd7);
        tick();
        set_d(5'd0, 5'd0, 4'd1, 4'd1, 4'd2, 5'd7);
        tick();
        set_d(5'd7, 5'd0, 4'd0, 4'd0, 4'hF, 5'd0);
        chk("ewins_stall", {3'b0, stall}, 4'd1);
        chk("ewins_fwd_rs_d", {2'b0, fwd_rs_d}, 4'd0);
        tick();
        chk("ewins_stall_after", {3'b0, stall}, 4'd0);
        chk("ewins_fwd_rs_d_after", {2'b0, fwd_rs_d}, 4'd2);
        drain();

        // Reset asserted in the middle of a stall
        set_d(5'd0, 5'd1, 4'd1, 4'hF, 4'd3, 5'd1);
        tick();
        set_d(5'd1, 5'd1, 4'd1, 4'd1, 4'd2, 5'd2);
        chk("rstmid_stall_before", {3'b0, stall}, 4'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall_during", {3'b0, stall}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // addu $6,$0,$0 ; addu $8,$6,$6 on a fresh pipeline
        set_d(5'd0, 5'd0, 4'd1, 4'd1, 4'd2, 5'd6);
        chk("fresh_addu_stall", {3'b0, stall}, 4'd0);
        tick();
        set_d(5'd6, 5'd6, 4'd1, 4'd1, 4'd2, 5'd8);
        chk("fresh_reader_stall", {3'b0, stall}, 4'd0);
        tick();
        nop();
        chk("fresh_fwd_rs_e", {2'b0, fwd_rs_e}, 4'd2);
        chk("fresh_fwd_rt_e", {2'b0, fwd_rt_e}, 4'd2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
